// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and default sizes for the pipeline hazard controller.
//   hc_state_t     : sequencer state (RUN, FLUSH, MEM_WAIT)
//   REG_IDX_W_DEF  : default register index width
//   NUM_REGS_DEF   : default scoreboard depth (2**REG_IDX_W_DEF)
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_IDX_W_DEF = 4;
    localparam int NUM_REGS_DEF  = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hc_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// One pending bit per architectural register, set when a writer issues and
// cleared at writeback, with three combinational lookup ports for decode.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_set, i_set_idx      mark register as having an in-flight writer
//   i_clr, i_clr_idx      writeback retires the pending write
//   i_ra, i_rb, i_rc      lookup indices
//   o_pend_ra/rb/rc       pending bit of each looked-up register
//   o_pending             full scoreboard vector
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_IDX_W = hazard_pkg::REG_IDX_W_DEF,
    parameter int NUM_REGS  = hazard_pkg::NUM_REGS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_set,
    input  logic [REG_IDX_W-1:0] i_set_idx,
    input  logic                 i_clr,
    input  logic [REG_IDX_W-1:0] i_clr_idx,
    input  logic [REG_IDX_W-1:0] i_ra,
    input  logic [REG_IDX_W-1:0] i_rb,
    input  logic [REG_IDX_W-1:0] i_rc,
    output logic                 o_pend_ra,
    output logic                 o_pend_rb,
    output logic                 o_pend_rc,
    output logic [NUM_REGS-1:0]  o_pending
);

    logic [NUM_REGS-1:0] r_sb;
    logic [NUM_REGS-1:0] w_sb_nxt;

    // Clear first, then set, so a same-index set+clear leaves the bit set:
    // the newly issued writer is still in flight.
    always_comb begin
        w_sb_nxt = r_sb;
        if (i_clr) w_sb_nxt[i_clr_idx] = 1'b0;
        if (i_set) w_sb_nxt[i_set_idx] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sb <= '0;
        else          r_sb <= w_sb_nxt;
    end

    // Lookups read the registered vector: no writeback bypass.
    assign o_pend_ra = r_sb[i_ra];
    assign o_pend_rb = r_sb[i_rb];
    assign o_pend_rc = r_sb[i_rc];
    assign o_pending = r_sb;

endmodule

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Pipeline sequencer beside decode. Detects RAW/WAW hazards with a register
// scoreboard, drives IF/ID and ID/EX enables and flushes, squashes wrong-path
// work after a taken branch and freezes the pipe while memory is busy.
// Optional feature macro: HAZARD_PERF_EN (saturating stall/flush counters).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   id_valid                 decode holds a real instruction
//   id_ra, id_rb, id_rc      decode source / dest indices
//   id_use_ra/rb/rc          source actually read
//   id_reg_write             instruction writes id_rc
//   wb_we, wb_rd             writeback enable / index
//   ex_br_taken              branch in EX resolved taken
//   mem_busy                 data memory not ready
//   if_en, ifid_en, idex_en  stage/buffer enables
//   ifid_flush, idex_flush   load bubble into buffer
//   id_issue                 decode instruction advances
//   sb_pending               scoreboard bits (debug)
//   stall_cnt, flush_cnt     perf counters (zero unless HAZARD_PERF_EN)
// -----------------------------------------------------------------------------
module hazard_controller #(
    parameter int REG_IDX_W  = hazard_pkg::REG_IDX_W_DEF,
    parameter int NUM_REGS   = hazard_pkg::NUM_REGS_DEF,
    parameter int FLUSH_CYC  = 2,
    parameter int PERF_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_IDX_W-1:0]  id_ra,
    input  logic [REG_IDX_W-1:0]  id_rb,
    input  logic [REG_IDX_W-1:0]  id_rc,
    input  logic                  id_use_ra,
    input  logic                  id_use_rb,
    input  logic                  id_use_rc,
    input  logic                  id_reg_write,
    input  logic                  wb_we,
    input  logic [REG_IDX_W-1:0]  wb_rd,
    input  logic                  ex_br_taken,
    input  logic                  mem_busy,
    output logic                  if_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  id_issue,
    output logic [NUM_REGS-1:0]   sb_pending,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
);

    import hazard_pkg::*;

    localparam int CTR_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    hc_state_t        r_state, w_state_nxt;
    hc_state_t        r_saved, w_saved_nxt;
    hc_state_t        w_eff_state;
    logic [CTR_W-1:0] r_ctr, w_ctr_nxt;

    logic w_pend_ra, w_pend_rb, w_pend_rc;
    logic w_hazard;

    hazard_scoreboard #(
        .REG_IDX_W (REG_IDX_W),
        .NUM_REGS  (NUM_REGS)
    ) u_sb (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_set     (id_issue & id_reg_write),
        .i_set_idx (id_rc),
        .i_clr     (wb_we),
        .i_clr_idx (wb_rd),
        .i_ra      (id_ra),
        .i_rb      (id_rb),
        .i_rc      (id_rc),
        .o_pend_ra (w_pend_ra),
        .o_pend_rb (w_pend_rb),
        .o_pend_rc (w_pend_rc),
        .o_pending (sb_pending)
    );

    // id_rc is checked both as a source (store data) and as a destination
    // (WAW), which keeps at most one writer per register in flight.
    assign w_hazard = id_valid & ((id_use_ra & w_pend_ra) |
                                  (id_use_rb & w_pend_rb) |
                                  ((id_use_rc | id_reg_write) & w_pend_rc));

    // Once memory frees up, MEM_WAIT resumes the saved state's behaviour in
    // that same cycle, so no dead cycle follows the freeze.
    assign w_eff_state = (r_state == MEM_WAIT) ? r_saved : r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_saved <= RUN;
            r_ctr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_saved <= w_saved_nxt;
            r_ctr   <= w_ctr_nxt;
        end
    end

    always_comb begin
        if_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        id_issue    = 1'b0;
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        w_ctr_nxt   = r_ctr;

        if (mem_busy) begin
            // Full freeze; flush counter holds.
            if_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            w_state_nxt = MEM_WAIT;
            if (r_state != MEM_WAIT) w_saved_nxt = r_state;
        end else begin
            case (w_eff_state)
                FLUSH: begin
                    // EX holds a bubble here, so a taken branch is ignored.
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    w_ctr_nxt   = r_ctr - 1'b1;
                    w_state_nxt = (r_ctr <= CTR_W'(1)) ? RUN : FLUSH;
                end
                default: begin
                    w_state_nxt = RUN;
                    if (ex_br_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        w_ctr_nxt   = CTR_W'(FLUSH_CYC - 1);
                        w_state_nxt = (FLUSH_CYC == 1) ? RUN : FLUSH;
                    end else if (w_hazard) begin
                        // Hold fetch/decode, push a bubble into EX.
                        if_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else begin
                        id_issue = id_valid;
                    end
                end
            endcase
        end

        if (!rst) begin
            if_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            id_issue   = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_CNT_W-1:0] r_stall_cnt;
    logic [PERF_CNT_W-1:0] r_flush_cnt;
    logic                  w_stall_evt;
    logic                  w_flush_evt;

    // A hazard bubble flushes only ID/EX; branch squashes flush both buffers.
    assign w_stall_evt = mem_busy | (idex_flush & ~ifid_flush);
    assign w_flush_evt = ifid_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller. Control outputs are viewed as the
// vector {if_en, ifid_en, idex_en, ifid_flush, idex_flush, id_issue}.
module tb_hazard_controller;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_ra, id_use_rb, id_use_rc, id_reg_write;
    logic [3:0]    id_ra, id_rb, id_rc, wb_rd;
    logic          wb_we, ex_br_taken, mem_busy;
    logic          if_en, ifid_en, idex_en, ifid_flush, idex_flush, id_issue;
    logic [15:0]   sb_pending;
    logic [PW-1:0] stall_cnt, flush_cnt;
    logic [5:0]    ctl;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] C_RST   = 6'b000110;
    localparam logic [5:0] C_ISSUE = 6'b111001;
    localparam logic [5:0] C_IDLE  = 6'b111000;
    localparam logic [5:0] C_HAZ   = 6'b001010;
    localparam logic [5:0] C_FLUSH = 6'b111110;
    localparam logic [5:0] C_FRZ   = 6'b000000;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    assign ctl = {if_en, ifid_en, idex_en, ifid_flush, idex_flush, id_issue};

    always #5 clk = ~clk;

    hazard_controller #(
        .REG_IDX_W  (4),
        .NUM_REGS   (16),
        .FLUSH_CYC  (2),
        .PERF_CNT_W (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_ra        (id_ra),
        .id_rb        (id_rb),
        .id_rc        (id_rc),
        .id_use_ra    (id_use_ra),
        .id_use_rb    (id_use_rb),
        .id_use_rc    (id_use_rc),
        .id_reg_write (id_reg_write),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .ex_br_taken  (ex_br_taken),
        .mem_busy     (mem_busy),
        .if_en        (if_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .id_issue     (id_issue),
        .sb_pending   (sb_pending),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_use_ra = 0; id_use_rb = 0; id_use_rc = 0; id_reg_write = 0;
        id_ra = 0; id_rb = 0; id_rc = 0; wb_we = 0; wb_rd = 0;
        ex_br_taken = 0; mem_busy = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #2;
        total++; if (ctl !== C_RST) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST); end
        tick();
        rst = 1'b1;
        // issue a write to R4 so the scoreboard holds 0x0010
        id_valid = 1; id_rc = 4; id_reg_write = 1;
        #2;
        total++; if (ctl !== C_ISSUE) begin bad++; $display("FAIL reset_issue_r4 got=%b exp=%b", ctl, C_ISSUE); end
        tick();
        idle_inputs();
        total++; if (sb_pending !== 16'h0010) begin bad++; $display("FAIL reset_sb_set got=%h exp=0010", sb_pending); end
        #2 rst = 1'b0;
        #1;
        total++; if (ctl !== C_RST) begin bad++; $display("FAIL reset_async_ctl got=%b exp=%b", ctl, C_RST); end
        total++; if (sb_pending !== 16'h0000) begin bad++; $display("FAIL reset_async_sb got=%h exp=0000", sb_pending); end
        tick();
        rst = 1'b1;
        id_valid = 1; id_use_ra = 1; id_ra = 4;
        #2;
        total++; if (ctl !== C_ISSUE) begin bad++; $display("FAIL reset_run_after got=%b exp=%b", ctl, C_ISSUE); end
        tick();
        idle_inputs();
    endtask

    task automatic test_raw();
        id_valid = 1; id_rc = 3; id_reg_write = 1;
        #2;
        total++; if (ctl !== C_ISSUE) begin bad++; $display("FAIL raw_issue_w3 got=%b exp=%b", ctl, C_ISSUE); end
        tick();
        total++; if (sb_pending !== 16'h0008) begin bad++; $display("FAIL raw_sb got=%h exp=0008", sb_pending); end
        id_rc = 0; id_reg_write = 0; id_ra = 3; id_use_ra = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++; if (ctl !== C_HAZ) begin bad++; $display("FAIL raw_bubble%0d got=%b exp=%b", i, ctl, C_HAZ); end
            tick();
        end
        wb_we = 1; wb_rd = 3;
        #2;
        total++; if (ctl !== C_HAZ) begin bad++; $display("FAIL raw_wb_cycle got=%b exp=%b", ctl, C_HAZ); end
        tick();
        wb_we = 0;
        #2;
        total++; if (ctl !== C_ISSUE) begin bad++; $display("FAIL raw_release got=%b exp=%b", ctl, C_ISSUE); end
        total++; if (sb_pending !== 16'h0000) begin bad++; $display("FAIL raw_sb_clear got=%h exp=0000", sb_pending); end
        tick();
        idle_inputs();
    endtask

    task automatic test_branch();
        id_valid = 1; id_rc = 6; id_reg_write = 1; ex_br_taken = 1;
        #2;
        total++; if (ctl !== C_FLUSH) begin bad++; $display("FAIL br_flush0 got=%b exp=%b", ctl, C_FLUSH); end
        tick();
        #2;
        total++; if (ctl !== C_FLUSH) begin bad++; $display("FAIL br_flush1 got=%b exp=%b", ctl, C_FLUSH); end
        tick();
        idle_inputs();
        #2;
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL br_back_run got=%b exp=%b", ctl, C_IDLE); end
        total++; if (sb_pending !== 16'h0000) begin bad++; $display("FAIL br_no_sb_set got=%h exp=0000", sb_pending); end
        tick();
    endtask

    task automatic test_mem_flush();
        ex_br_taken = 1;
        #2;
        total++; if (ctl !== C_FLUSH) begin bad++; $display("FAIL mem_br got=%b exp=%b", ctl, C_FLUSH); end
        tick();
        ex_br_taken = 0; mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++; if (ctl !== C_FRZ) begin bad++; $display("FAIL mem_freeze%0d got=%b exp=%b", i, ctl, C_FRZ); end
            tick();
        end
        mem_busy = 0;
        #2;
        total++; if (ctl !== C_FLUSH) begin bad++; $display("FAIL mem_last_flush got=%b exp=%b", ctl, C_FLUSH); end
        tick();
        #2;
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL mem_run got=%b exp=%b", ctl, C_IDLE); end
        tick();
        // freeze from RUN with a valid instruction, then resume issuing
        id_valid = 1; mem_busy = 1;
        #2;
        total++; if (ctl !== C_FRZ) begin bad++; $display("FAIL mem_run_freeze got=%b exp=%b", ctl, C_FRZ); end
        tick();
        mem_busy = 0;
        #2;
        total++; if (ctl !== C_ISSUE) begin bad++; $display("FAIL mem_run_resume got=%b exp=%b", ctl, C_ISSUE); end
        tick();
        idle_inputs();
    endtask

    task automatic test_same_cycle();
        id_valid = 1; id_rc = 5; id_reg_write = 1; wb_we = 1; wb_rd = 5;
        #2;
        total++; if (ctl !== C_ISSUE) begin bad++; $display("FAIL same_issue got=%b exp=%b", ctl, C_ISSUE); end
        tick();
        total++; if (sb_pending !== 16'h0020) begin bad++; $display("FAIL same_set_wins got=%h exp=0020", sb_pending); end
        id_valid = 0; id_reg_write = 0;
        tick();
        wb_we = 0;
        total++; if (sb_pending !== 16'h0000) begin bad++; $display("FAIL same_clear got=%h exp=0000", sb_pending); end
        id_valid = 1; id_rc = 7; id_reg_write = 1;
        #2;
        total++; if (ctl !== C_ISSUE) begin bad++; $display("FAIL waw_first got=%b exp=%b", ctl, C_ISSUE); end
        tick();
        #2;
        total++; if (ctl !== C_HAZ) begin bad++; $display("FAIL waw_stall got=%b exp=%b", ctl, C_HAZ); end
        tick();
        total++; if (sb_pending !== 16'h0080) begin bad++; $display("FAIL waw_sb got=%h exp=0080", sb_pending); end
        id_reg_write = 0; id_rc = 0; id_use_rb = 1; id_rb = 7;
        #2;
        total++; if (ctl !== C_HAZ) begin bad++; $display("FAIL rb_stall got=%b exp=%b", ctl, C_HAZ); end
        idle_inputs();
        wb_we = 1; wb_rd = 7;
        tick();
        wb_we = 0;
        total++; if (sb_pending !== 16'h0000) begin bad++; $display("FAIL waw_clear got=%h exp=0000", sb_pending); end
    endtask

    task automatic test_perf();
        logic [PW-1:0] exp5, exp15, exp2;
        exp5  = PERF ? PW'(5)  : '0;
        exp15 = PERF ? PW'(15) : '0;
        exp2  = PERF ? PW'(2)  : '0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++; if (stall_cnt !== '0) begin bad++; $display("FAIL perf_stall_rst got=%0d exp=0", stall_cnt); end
        total++; if (flush_cnt !== '0) begin bad++; $display("FAIL perf_flush_rst got=%0d exp=0", flush_cnt); end
        mem_busy = 1;
        for (int i = 0; i < 5; i++) tick();
        total++; if (stall_cnt !== exp5) begin bad++; $display("FAIL perf_stall5 got=%0d exp=%0d", stall_cnt, exp5); end
        for (int i = 0; i < 15; i++) tick();
        total++; if (stall_cnt !== exp15) begin bad++; $display("FAIL perf_stall_sat got=%0d exp=%0d", stall_cnt, exp15); end
        mem_busy = 0;
        tick();
        ex_br_taken = 1;
        tick();
        ex_br_taken = 0;
        tick();
        total++; if (flush_cnt !== exp2) begin bad++; $display("FAIL perf_flush got=%0d exp=%0d", flush_cnt, exp2); end
        total++; if (stall_cnt !== exp15) begin bad++; $display("FAIL perf_stall_hold got=%0d exp=%0d", stall_cnt, exp15); end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_branch();
        test_mem_flush();
        test_same_cycle();
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
